gain_update: RTL and testbench

- Stage directly downstream of the gain predictor / gain quantizer in the G.729 encoder (Qua_gain path).
- Once the quantized codebook gain L_gbk12 (Q12 energy product) is known, the block updates the 4-entry past_qua_en history in scratch memory.
- The update is: shift the history by one, then write the new quantized energy, computed as 20*log10 scaled (Log2 -> L_Comp -> shl 13 -> mult 24660), into entry 0.
- The next subframe's gain prediction then consumes the updated history.

---
 rtl/gain_update.sv | 124 ++++++++++++
 tb/tb_gain_update.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_update.sv
// gain_update: shifts the 4-entry past_qua_en history down by one and writes the new quantized energy into entry 0.
// Latency: done rises on the 10th rising clock edge after the edge that accepts start.
module gain_update #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] PAST_QUA_EN = ADDR_W'(100)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       L_gbk12,
    input  logic [DATA_W-1:0] scratch_mem_in,
    output logic [ADDR_W-1:0] scratch_mem_read_addr,
    output logic [ADDR_W-1:0] scratch_mem_write_addr,
    output logic [DATA_W-1:0] scratch_mem_out,
    output logic              scratch_mem_write_en,
    output logic              done
);
    typedef enum logic [3:0] {IDLE, RD2, WT2, WR3, RD1, WT1, WR2, RD0, WT0, WR1, WR0, DONE} state_t;

    localparam logic [15:0] TAB_LOG [0:32] = '{
        16'd0,     16'd1455,  16'd2866,  16'd4236,  16'd5568,  16'd6863,  16'd8124,  16'd9352,
        16'd10549, 16'd11716, 16'd12855, 16'd13967, 16'd15054, 16'd16117, 16'd17156, 16'd18172,
        16'd19167, 16'd20142, 16'd21097, 16'd22033, 16'd22951, 16'd23852, 16'd24735, 16'd25603,
        16'd26455, 16'd27291, 16'd28113, 16'd28922, 16'd29716, 16'd30497, 16'd31266, 16'd32023,
        16'd32767
    };

    state_t              state_q, state_d;
    logic                start_q;
    logic [31:0]         l_q;
    logic [DATA_W-1:0]   data_q;
    logic [4:0]          exp_q, exp_d, msb;
    logic [19:0]         xn_q, xn_d;
    logic                pos_q, pos_d;
    logic [12:0]         frac_q, frac_d;
    logic [15:0]         q_q, q_d;
    logic                accept;
    logic [5:0]          idx;
    logic [15:0]         t0, t1;
    logic signed [16:0]  dt;
    logic signed [32:0]  msu;
    logic signed [5:0]   e;
    logic signed [15:0]  tmp;
    logic signed [31:0]  prod;

    assign accept = start & ~start_q & (state_q == IDLE || state_q == DONE);

    // Normalisation: exponent equals the index of the leading one of a positive input.
    always_comb begin
        msb = '0;
        for (int k = 1; k < 31; k++) if (l_q[k]) msb = 5'(k);
        pos_d = ~l_q[31] & (|l_q[30:0]);
        exp_d = pos_d ? msb : '0;
        xn_d  = 20'((l_q[30:0] << (5'd30 - msb)) >> 10);
    end

    // Table interpolation; only frac[14:2] survives the later shl-13 / extract_h.
    always_comb begin
        idx    = {1'b0, xn_q[19:15]};
        t0     = TAB_LOG[idx];
        t1     = TAB_LOG[idx + 6'd1];
        dt     = $signed({1'b0, t0}) - $signed({1'b0, t1});
        msu    = dt * $signed({1'b0, xn_q[14:0]});
        frac_d = pos_q ? 13'(($signed({1'b0, t0, 16'b0}) - (msu <<< 1)) >>> 18) : '0;
    end

    // L_acc<<13 overflows exactly when exp-13 lies outside -4..3; otherwise hi16 is {e[2:0], frac[14:2]}.
    always_comb begin
        e    = $signed({1'b0, exp_q}) - 6'sd13;
        tmp  = (e >= 6'sd4) ? 16'sh7FFF : (e < -6'sd4) ? 16'sh8000 : {e[2:0], frac_q};
        prod = tmp * 32'sd24660;
        q_d  = 16'(prod >>> 15);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? RD2 : state_q;
            WR0:        state_d = DONE;
            default:    state_d = state_t'(state_q + 4'd1);
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            l_q     <= '0;
            data_q  <= '0;
            exp_q   <= '0;
            xn_q    <= '0;
            pos_q   <= 1'b0;
            frac_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            if (accept) l_q <= L_gbk12;
            if (state_q == RD2) begin
                exp_q <= exp_d;
                xn_q  <= xn_d;
                pos_q <= pos_d;
            end
            if (state_q == WT2) frac_q <= frac_d;
            if (state_q == WR3) q_q <= q_d;
            if (state_q inside {WT2, WT1, WT0}) data_q <= scratch_mem_in;
        end
    end

    always_comb begin
        done                 = state_q == DONE;
        scratch_mem_write_en = state_q inside {WR3, WR2, WR1, WR0};
        scratch_mem_read_addr  = (state_q inside {RD2, WT2, WR3}) ? PAST_QUA_EN + ADDR_W'(2) :
                                 (state_q inside {RD1, WT1, WR2}) ? PAST_QUA_EN + ADDR_W'(1) :
                                 (state_q inside {RD0, WT0, WR1, WR0}) ? PAST_QUA_EN : '0;
        scratch_mem_write_addr = (state_q == WR3) ? PAST_QUA_EN + ADDR_W'(3) :
                                 (state_q == WR2) ? PAST_QUA_EN + ADDR_W'(2) :
                                 (state_q == WR1) ? PAST_QUA_EN + ADDR_W'(1) :
                                 (state_q == WR0) ? PAST_QUA_EN : '0;
        scratch_mem_out = (state_q == WR0) ? {{(DATA_W-16){q_q[15]}}, q_q} :
                          (state_q inside {WR3, WR2, WR1}) ? data_q : '0;
    end
endmodule

// File: tb/tb_gain_update.sv
// tb_gain_update: directed and chained-random checks of the past_qua_en history update against a behavioural G.729 model.
module tb_gain_update;
    localparam logic [11:0] BASE = 12'd100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] L_gbk12 = '0;
    logic [31:0] mem_rd;
    logic [11:0] raddr, waddr;
    logic [31:0] wdata;
    logic        we, done;

    logic [31:0] mem [0:4095];
    logic        load = 1'b0;
    logic [31:0] ld [4];
    int          wr_cnt = 0;
    logic [11:0] last_wa = '0;
    int          checks = 0;
    int          errors = 0;

    int tab [0:32] = '{0, 1455, 2866, 4236, 5568, 6863, 8124, 9352, 10549, 11716, 12855, 13967,
                       15054, 16117, 17156, 18172, 19167, 20142, 21097, 22033, 22951, 23852, 24735,
                       25603, 26455, 27291, 28113, 28922, 29716, 30497, 31266, 32023, 32767};

    gain_update #(.ADDR_W(12), .DATA_W(32), .PAST_QUA_EN(BASE)) dut (
        .clock(clock), .reset(reset), .start(start), .L_gbk12(L_gbk12),
        .scratch_mem_in(mem_rd), .scratch_mem_read_addr(raddr), .scratch_mem_write_addr(waddr),
        .scratch_mem_out(wdata), .scratch_mem_write_en(we), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        mem_rd <= mem[raddr];
        if (load) begin
            for (int k = 0; k < 4; k++) mem[BASE + 12'(k)] <= ld[k];
        end else if (we) begin
            mem[waddr] <= wdata;
            wr_cnt     <= wr_cnt + 1;
            last_wa    <= waddr;
        end
    end

    function automatic logic [31:0] ref_q(input logic [31:0] l);
        longint x, ly, acc;
        int ex, f, i, a, tmp, n;
        if ($signed(l) <= 0) begin
            ex = 0;
            f  = 0;
        end else begin
            x = longint'(l);
            n = 0;
            while (x[30] == 1'b0) begin
                x = x * 2;
                n++;
            end
            ex = 30 - n;
            i  = int'(x >> 25) - 32;
            a  = int'((x >> 10) & 64'h7fff);
            ly = (longint'(tab[i]) * 65536) - 2 * longint'(tab[i] - tab[i+1]) * longint'(a);
            f  = int'(ly >>> 16);
        end
        acc = longint'(ex - 13) * 65536 + 2 * longint'(f);
        acc = acc * 8192;
        if (acc > 64'sh7FFFFFFF) acc = 64'sh7FFFFFFF;
        else if (acc < -64'sh80000000) acc = -64'sh80000000;
        tmp = int'(acc >>> 16);
        return 32'((tmp * 24660) >>> 15);
    endfunction

    task automatic load_hist(input logic [31:0] h0, h1, h2, h3);
        ld[0] = h0; ld[1] = h1; ld[2] = h2; ld[3] = h3;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] l, output int cyc);
        L_gbk12 = l;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
        checks++; if (raddr !== 12'd0) begin errors++; $display("FAIL reset_raddr got %h want 000", raddr); end
        checks++; if (waddr !== 12'd0) begin errors++; $display("FAIL reset_waddr got %h want 000", waddr); end
        checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", wdata); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        logic [31:0] ex [4];
        int cyc, w0;
        load_hist(32'hFFFFF000, 32'hFFFFF100, 32'hFFFFF200, 32'hFFFFF300);
        w0 = wr_cnt;
        run_op(32'h00004000, cyc);
        ex = '{32'h00001815, 32'hFFFFF000, 32'hFFFFF100, 32'hFFFFF200};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[BASE + 12'(k)] !== ex[k]) begin errors++; $display("FAIL basic_entry%0d got %h want %h", k, mem[BASE + 12'(k)], ex[k]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done); end
        checks++; if (wr_cnt - w0 != 4) begin errors++; $display("FAIL basic_strobes got %0d want 4", wr_cnt - w0); end
        checks++; if (cyc != 11) begin errors++; $display("FAIL basic_latency got %0d want 11", cyc); end
        checks++; if (last_wa !== BASE) begin errors++; $display("FAIL basic_last_write got %h want %h", last_wa, BASE); end
    endtask

    task automatic test_zero_frac;
        logic [31:0] ex [4];
        int cyc;
        load_hist(32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D);
        run_op(32'h00002000, cyc);
        ex = '{32'h00000000, 32'h0000000A, 32'h0000000B, 32'h0000000C};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[BASE + 12'(k)] !== ex[k]) begin errors++; $display("FAIL zero_entry%0d got %h want %h", k, mem[BASE + 12'(k)], ex[k]); end
        end
        repeat (3) @(negedge clock);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b want 1", done); end
    endtask

    task automatic test_saturation;
        logic [31:0] ex [4];
        int cyc;
        load_hist(32'h1, 32'h2, 32'h3, 32'h4);
        run_op(32'h00000000, cyc);
        checks++; if (mem[BASE] !== 32'hFFFF9FAC) begin errors++; $display("FAIL sat_zero got %h want FFFF9FAC", mem[BASE]); end
        run_op(32'h80000000, cyc);
        ex = '{32'hFFFF9FAC, 32'hFFFF9FAC, 32'h1, 32'h2};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[BASE + 12'(k)] !== ex[k]) begin errors++; $display("FAIL sat_neg_entry%0d got %h want %h", k, mem[BASE + 12'(k)], ex[k]); end
        end
    endtask

    task automatic test_chained_random;
        logic [31:0] h [4];
        logic [31:0] l;
        int cyc;
        load_hist(32'hFFFFC800, 32'hFFFFC800, 32'hFFFFC800, 32'hFFFFC800);
        h = '{32'hFFFFC800, 32'hFFFFC800, 32'hFFFFC800, 32'hFFFFC800};
        for (int s = 0; s < 60; s++) begin
            l = $urandom >> $urandom_range(0, 30);
            l[31] = 1'b0;
            if (l == 32'd0) l = 32'd1;
            run_op(l, cyc);
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = ref_q(l);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (mem[BASE + 12'(k)] !== h[k]) begin errors++; $display("FAIL chain_s%0d_entry%0d L=%h got %h want %h", s, k, l, mem[BASE + 12'(k)], h[k]); end
            end
        end
    endtask

    task automatic test_busy_restart;
        logic [31:0] ex [4];
        int cyc, w0;
        load_hist(32'h1, 32'h2, 32'h3, 32'h4);
        w0 = wr_cnt;
        L_gbk12 = 32'h00008000;
        start = 1'b1;
        @(negedge clock); start = 1'b0; cyc = 1;
        @(negedge clock); cyc++;
        L_gbk12 = 32'h00002000;
        start = 1'b1;
        @(negedge clock); start = 1'b0; cyc++;
        while (!done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        ex = '{32'h0000302A, 32'h1, 32'h2, 32'h3};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[BASE + 12'(k)] !== ex[k]) begin errors++; $display("FAIL busy_entry%0d got %h want %h", k, mem[BASE + 12'(k)], ex[k]); end
        end
        checks++; if (cyc != 11) begin errors++; $display("FAIL busy_latency got %0d want 11", cyc); end
        checks++; if (wr_cnt - w0 != 4) begin errors++; $display("FAIL busy_strobes got %0d want 4", wr_cnt - w0); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] ex [4];
        int cyc, n;
        load_hist(32'h11, 32'h22, 32'h33, 32'h44);
        L_gbk12 = 32'h00004000;
        start = 1'b1;
        @(negedge clock); start = 1'b0; n = 0;
        while (!(we && waddr == BASE + 12'd2) && n < 30) begin
            @(negedge clock);
            n++;
        end
        checks++; if (n >= 30) begin errors++; $display("FAIL midreset_reach_wr2 got timeout want WR2"); end
        reset = 1'b1;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL midreset_we got %b want 0", we); end
        checks++; if (waddr !== 12'd0) begin errors++; $display("FAIL midreset_waddr got %h want 000", waddr); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        ex = '{32'h11, 32'h22, 32'h33, 32'h33};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[BASE + 12'(k)] !== ex[k]) begin errors++; $display("FAIL midreset_mem%0d got %h want %h", k, mem[BASE + 12'(k)], ex[k]); end
        end
        load_hist(32'h11, 32'h22, 32'h33, 32'h44);
        run_op(32'h00004000, cyc);
        ex = '{32'h00001815, 32'h11, 32'h22, 32'h33};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[BASE + 12'(k)] !== ex[k]) begin errors++; $display("FAIL rerun_entry%0d got %h want %h", k, mem[BASE + 12'(k)], ex[k]); end
        end
        checks++; if (cyc != 11) begin errors++; $display("FAIL rerun_latency got %0d want 11", cyc); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ex [4];
        int cyc, w0;
        load_hist(32'h5, 32'h6, 32'h7, 32'h8);
        w0 = wr_cnt;
        run_op(32'h00004000, cyc);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
        L_gbk12 = 32'h00002000;
        start = 1'b1;
        @(negedge clock); start = 1'b0; cyc = 1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got %b want 0", done); end
        while (!done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        ex = '{32'h00000000, 32'h00001815, 32'h5, 32'h6};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[BASE + 12'(k)] !== ex[k]) begin errors++; $display("FAIL b2b_entry%0d got %h want %h", k, mem[BASE + 12'(k)], ex[k]); end
        end
        checks++; if (cyc != 11) begin errors++; $display("FAIL b2b_latency got %0d want 11", cyc); end
        checks++; if (wr_cnt - w0 != 8) begin errors++; $display("FAIL b2b_strobes got %0d want 8", wr_cnt - w0); end
    endtask

    initial begin
        @(negedge clock);
        test_reset;
        test_basic;
        test_zero_frac;
        test_saturation;
        test_chained_random;
        test_busy_restart;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
